// File: rtl/rx_byte_packer_if.sv
// rx_byte_packer_if: receiver strobes in, packed word stream and drop counter out
interface rx_byte_packer_if #(
    parameter int RSSI_HALF_DB_WIDTH = 11
) ();
    logic [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db;
    logic                          pkt_header_valid_strobe;
    logic                          pkt_header_valid;
    logic [7:0]                    pkt_rate;
    logic [15:0]                   pkt_len;
    logic                          ht_aggr;
    logic                          ht_sgi;
    logic                          byte_out_strobe;
    logic [7:0]                    byte_out;
    logic                          fcs_out_strobe;
    logic                          fcs_ok;
    logic [63:0]                   word_out;
    logic                          word_valid;
    logic                          word_ready;
    logic                          word_first;
    logic                          word_last;
    logic [15:0]                   drop_cnt;

    modport slave (
        input  rssi_half_db, pkt_header_valid_strobe, pkt_header_valid, pkt_rate, pkt_len,
               ht_aggr, ht_sgi, byte_out_strobe, byte_out, fcs_out_strobe, fcs_ok, word_ready,
        output word_out, word_valid, word_first, word_last, drop_cnt
    );

    modport master (
        output rssi_half_db, pkt_header_valid_strobe, pkt_header_valid, pkt_rate, pkt_len,
               ht_aggr, ht_sgi, byte_out_strobe, byte_out, fcs_out_strobe, fcs_ok, word_ready,
        input  word_out, word_valid, word_first, word_last, drop_cnt
    );
endinterface

// File: rtl/rx_byte_packer.sv
// rx_byte_packer: frames receiver bytes into header/data/status 64-bit words through a FWFT FIFO
module rx_byte_packer #(
    parameter int FIFO_DEPTH         = 16,
    parameter int RSSI_HALF_DB_WIDTH = 11
) (
    input logic           clock,
    input logic           reset,
    rx_byte_packer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, STATUS, HDR_PEND} state_t;

    localparam int             AW     = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    FULL   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]    ALMOST = (AW+1)'(FIFO_DEPTH - 1);

    state_t             state, state_n;
    logic [65:0]        mem [FIFO_DEPTH];
    logic [65:0]        head;
    logic [AW:0]        wp, rp, occ;
    logic [63:0]        acc, acc_n, pend_hdr, hdr_word, stat_word, push_word;
    logic [2:0]         idx, idx_n;
    logic [15:0]        bytes_rcvd, cur_len, drop_cnt;
    logic signed [15:0] rssi16;
    logic               fcs_r, aborted, overflow;
    logic               valid, pop, hdr_ok, pkt_end, wrap, start;
    logic               push, push_first, push_last, drop;

    assign rssi16    = 16'(signed'(bus.rssi_half_db));
    assign hdr_word  = {rssi16, bus.pkt_rate, 6'b0, bus.ht_sgi, bus.ht_aggr, bus.pkt_len, 16'h0};
    assign stat_word = {fcs_r & ~aborted, aborted, overflow, 13'b0, cur_len, bytes_rcvd, 16'h0};
    assign hdr_ok    = bus.pkt_header_valid_strobe & bus.pkt_header_valid;
    assign pkt_end   = hdr_ok | bus.fcs_out_strobe;
    assign acc_n     = bus.byte_out_strobe ? acc | (64'(bus.byte_out) << {idx, 3'b000}) : acc;
    assign idx_n     = idx + 3'(bus.byte_out_strobe);
    assign wrap      = bus.byte_out_strobe && idx == 3'd7;
    assign start     = (state == IDLE && hdr_ok) || state == HDR_PEND;
    assign occ       = wp - rp;
    assign valid     = occ != '0;
    assign pop       = valid & bus.word_ready;
    assign drop      = push && (push_last ? (occ == FULL && !pop) : occ >= ALMOST);

    // Packet framing: choose what (if anything) to push this cycle and where to go next
    always_comb begin
        state_n    = state;
        push       = 1'b0;
        push_word  = acc_n;
        push_first = 1'b0;
        push_last  = 1'b0;
        case (state)
            IDLE: begin
                push       = hdr_ok;
                push_word  = hdr_word;
                push_first = 1'b1;
                state_n    = hdr_ok ? DATA : IDLE;
            end
            DATA: begin
                push    = wrap | (pkt_end && idx_n != 3'd0);
                state_n = pkt_end ? STATUS : DATA;
            end
            STATUS: begin
                push      = 1'b1;
                push_word = stat_word;
                push_last = 1'b1;
                state_n   = aborted ? HDR_PEND : IDLE;
            end
            default: begin
                push       = 1'b1;
                push_word  = pend_hdr;
                push_first = 1'b1;
                state_n    = DATA;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Per-packet accumulator, byte count, status flags and pending header
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            idx        <= '0;
            bytes_rcvd <= '0;
            cur_len    <= '0;
            pend_hdr   <= '0;
            fcs_r      <= 1'b0;
            aborted    <= 1'b0;
            overflow   <= 1'b0;
        end else if (start) begin
            acc        <= '0;
            idx        <= '0;
            bytes_rcvd <= '0;
            fcs_r      <= 1'b0;
            aborted    <= 1'b0;
            overflow   <= drop;
            cur_len    <= state == HDR_PEND ? pend_hdr[31:16] : bus.pkt_len;
        end else if (state == DATA) begin
            acc      <= (wrap || pkt_end) ? '0 : acc_n;
            idx      <= pkt_end ? '0 : idx_n;
            overflow <= overflow | drop;
            if (bus.byte_out_strobe && bytes_rcvd != 16'hFFFF) bytes_rcvd <= bytes_rcvd + 16'd1;
            if (hdr_ok) begin
                aborted  <= 1'b1;
                pend_hdr <= hdr_word;
            end else if (bus.fcs_out_strobe) begin
                fcs_r <= bus.fcs_ok;
            end
        end
    end

    // FIFO pointers and saturating drop counter
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            drop_cnt <= '0;
        end else begin
            wp <= wp + (AW+1)'(push & ~drop);
            rp <= rp + (AW+1)'(pop);
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // FIFO storage: {first, last, word}
    always_ff @(posedge clock) begin
        if (push && !drop) mem[wp[AW-1:0]] <= {push_first, push_last, push_word};
    end

    assign head           = mem[rp[AW-1:0]];
    assign bus.word_valid = valid;
    assign bus.word_out   = valid ? head[63:0] : '0;
    assign bus.word_first = valid & head[65];
    assign bus.word_last  = valid & head[64];
    assign bus.drop_cnt   = drop_cnt;
endmodule
